gobou_net_loader: RTL and testbench

//   Upstream feeder for the gobou fully-connected engine's per-core weight memories.

---
 rtl/gobou_net_loader.sv | 141 ++++++++++++++
 tb/tb_gobou_net_loader.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gobou_net_loader.sv
// gobou_net_loader: streams neuron-major weight/bias words into the
// per-core net memories of the gobou FC engine, round-robin by neuron.
//
// Ports:
//   clk, xrst (sync, active-high)
//   req, net_offset, total_out, total_in, bias_en : job setup (latched on req)
//   s_valid, s_data, s_ready                       : weight word stream
//   net_sel, net_we, net_addr, net_wdata           : engine write port (registered)
//   busy, ack                                      : job status
module gobou_net_loader #(
  parameter int CORE    = 8,
  parameter int CORELOG = 3,
  parameter int NETSIZE = 11,
  parameter int WWIDTH  = 16,
  parameter int LWIDTH  = 10
) (
  input  logic               clk,
  input  logic               xrst,
  input  logic               req,
  input  logic [NETSIZE-1:0] net_offset,
  input  logic [LWIDTH-1:0]  total_out,
  input  logic [LWIDTH-1:0]  total_in,
  input  logic               bias_en,
  input  logic               s_valid,
  input  logic [WWIDTH-1:0]  s_data,
  output logic               s_ready,
  output logic [CORELOG-1:0] net_sel,
  output logic               net_we,
  output logic [NETSIZE-1:0] net_addr,
  output logic [WWIDTH-1:0]  net_wdata,
  output logic               busy,
  output logic               ack
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  localparam logic [LWIDTH:0]    ONE_R = 1;
  localparam logic [LWIDTH-1:0]  ONE_O = 1;
  localparam logic [CORELOG-1:0] ONE_C = 1;
  localparam logic [CORELOG-1:0] LAST_C = CORELOG'(CORE - 1);

  state_t state, state_n;

  logic [LWIDTH:0]    req_len;
  logic [LWIDTH:0]    r_len;
  logic [LWIDTH-1:0]  out_len;
  logic [NETSIZE-1:0] offset;
  logic [LWIDTH:0]    j_cnt;
  logic [LWIDTH-1:0]  o_cnt;
  logic [CORELOG-1:0] core;
  logic [NETSIZE-1:0] base;
  logic               xfer;
  logic               last_j;
  logic               last_o;

  assign req_len = {1'b0, total_in} + {{LWIDTH{1'b0}}, bias_en};
  assign xfer    = s_valid & s_ready;
  assign last_j  = (j_cnt == r_len - ONE_R);
  assign last_o  = (o_cnt == out_len - ONE_O);

  always_comb begin
    state_n = state;
    s_ready = 1'b0;
    busy    = 1'b1;
    ack     = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (req) begin
          if (total_out == '0 || req_len == '0)
            state_n = DONE;
          else
            state_n = LOAD;
        end
      end
      LOAD: begin
        s_ready = 1'b1;
        if (xfer && last_j && last_o)
          state_n = DONE;
      end
      DONE: begin
        ack     = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (xrst) begin
      state     <= IDLE;
      r_len     <= '0;
      out_len   <= '0;
      offset    <= '0;
      j_cnt     <= '0;
      o_cnt     <= '0;
      core      <= '0;
      base      <= '0;
      net_we    <= 1'b0;
      net_sel   <= '0;
      net_addr  <= '0;
      net_wdata <= '0;
    end else begin
      state  <= state_n;
      net_we <= xfer;
      if (xfer) begin
        net_sel   <= core;
        net_addr  <= offset + base + NETSIZE'(j_cnt);
        net_wdata <= s_data;
      end
      if (state == IDLE && req) begin
        r_len   <= req_len;
        out_len <= total_out;
        offset  <= net_offset;
        j_cnt   <= '0;
        o_cnt   <= '0;
        core    <= '0;
        base    <= '0;
      end else if (xfer) begin
        if (last_j) begin
          j_cnt <= '0;
          o_cnt <= o_cnt + ONE_O;
          // base tracks (o div CORE)*R without a multiplier
          if (core == LAST_C) begin
            core <= '0;
            base <= base + NETSIZE'(r_len);
          end else begin
            core <= core + ONE_C;
          end
        end else begin
          j_cnt <= j_cnt + ONE_R;
        end
      end
    end
  end

endmodule

// File: tb/tb_gobou_net_loader.sv
// tb_gobou_net_loader: scoreboard bench for gobou_net_loader.
// Expected writes are queued at stimulus time, popped on net_we.
module tb_gobou_net_loader;

  logic        clk = 1'b0;
  logic        xrst;
  logic        req;
  logic [10:0] net_offset;
  logic [9:0]  total_out;
  logic [9:0]  total_in;
  logic        bias_en;
  logic        s_valid;
  logic [15:0] s_data;
  logic        s_ready;
  logic [2:0]  net_sel;
  logic        net_we;
  logic [10:0] net_addr;
  logic [15:0] net_wdata;
  logic        busy;
  logic        ack;

  int n_checks = 0;
  int n_fail   = 0;
  int we_cnt   = 0;
  int ack_cnt  = 0;
  logic [29:0] exp_q[$];

  always #5 clk = ~clk;

  gobou_net_loader dut (
    .clk       (clk),
    .xrst      (xrst),
    .req       (req),
    .net_offset(net_offset),
    .total_out (total_out),
    .total_in  (total_in),
    .bias_en   (bias_en),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .net_sel   (net_sel),
    .net_we    (net_we),
    .net_addr  (net_addr),
    .net_wdata (net_wdata),
    .busy      (busy),
    .ack       (ack)
  );

  always @(negedge clk) begin
    logic [29:0] e;
    if (ack === 1'b1) ack_cnt++;
    if (net_we === 1'b1) begin
      we_cnt++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got sel=%0d addr=%h data=%h, required no write",
                 net_sel, net_addr, net_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({net_sel, net_addr, net_wdata} !== e) begin
          n_fail++;
          $display("FAIL write: got sel=%0d addr=%h data=%h, required sel=%0d addr=%h data=%h",
                   net_sel, net_addr, net_wdata, e[29:27], e[26:16], e[15:0]);
        end
      end
    end
  end

  function automatic void push_exp(input int n_out, input int n_in, input bit bias,
                                   input int off, input int d0, input int limit);
    int r;
    int k;
    logic [2:0]  s;
    logic [10:0] a;
    logic [15:0] d;
    r = n_in + int'(bias);
    k = 0;
    for (int o = 0; o < n_out; o++) begin
      for (int j = 0; j < r; j++) begin
        if (k < limit) begin
          s = 3'(o % 8);
          a = 11'(off + (o / 8) * r + j);
          d = 16'(d0 + k);
          exp_q.push_back({s, a, d});
        end
        k++;
      end
    end
  endfunction

  task automatic start_job(input int n_out, input int n_in, input bit bias,
                           input int off);
    @(posedge clk); #1;
    req        = 1'b1;
    total_out  = 10'(n_out);
    total_in   = 10'(n_in);
    bias_en    = bias;
    net_offset = 11'(off);
  endtask

  task automatic do_load(input int n_out, input int n_in, input bit bias,
                         input int off, input int gap, input int d0,
                         input bit hold_req, output int hs);
    int total;
    int k;
    int cyc;
    int we0;
    int ack0;
    bit hit;
    total = n_out * (n_in + int'(bias));
    hs  = 0;
    k   = 0;
    cyc = 0;
    push_exp(n_out, n_in, bias, off, d0, total);
    we0  = we_cnt;
    ack0 = ack_cnt;
    start_job(n_out, n_in, bias, off);
    @(posedge clk); #1;
    if (!hold_req) req = 1'b0;
    while (k < total && cyc < 4000) begin
      s_valid = (gap == 0) || ($urandom_range(99) >= gap);
      s_data  = 16'(d0 + k);
      @(negedge clk);
      hit = s_valid && s_ready;
      @(posedge clk); #1;
      if (hit) begin
        k++;
        hs++;
      end
      cyc++;
    end
    s_valid = 1'b0;
    n_checks++;
    if (k != total) begin
      n_fail++;
      $display("FAIL load_timeout: accepted %0d words, required %0d", k, total);
    end
    @(negedge clk);
    n_checks++;
    if (ack !== 1'b1 || net_we !== 1'b1) begin
      n_fail++;
      $display("FAIL ack_with_last_write: ack=%b net_we=%b, required 1 1", ack, net_we);
    end
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ack !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL back_to_idle: ack=%b busy=%b, required 0 0", ack, busy);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_writes: %0d left, required 0", exp_q.size());
      exp_q.delete();
    end
    n_checks++;
    if (we_cnt - we0 != hs) begin
      n_fail++;
      $display("FAIL we_count: got %0d, required %0d", we_cnt - we0, hs);
    end
    n_checks++;
    if (ack_cnt - ack0 != 1) begin
      n_fail++;
      $display("FAIL ack_count: got %0d, required 1", ack_cnt - ack0);
    end
  endtask

  task automatic test_reset();
    xrst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (s_ready !== 1'b0 || net_we !== 1'b0 || busy !== 1'b0 || ack !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: s_ready=%b net_we=%b busy=%b ack=%b, required 0 0 0 0",
               s_ready, net_we, busy, ack);
    end
    n_checks++;
    if (net_sel !== 3'd0 || net_addr !== 11'd0 || net_wdata !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_data: sel=%0d addr=%h data=%h, required 0 0 0",
               net_sel, net_addr, net_wdata);
    end
    @(posedge clk); #1;
    xrst = 1'b0;
  endtask

  task automatic test_basic();
    int hs;
    int we0;
    we0 = we_cnt;
    do_load(3, 2, 1'b1, 'h10, 0, 1, 1'b0, hs);
    n_checks++;
    if (we_cnt - we0 != 9) begin
      n_fail++;
      $display("FAIL basic_we_pulses: got %0d, required 9", we_cnt - we0);
    end
  endtask

  task automatic test_core_wrap();
    int hs;
    do_load(10, 1, 1'b0, 0, 0, 'h40, 1'b0, hs);
  endtask

  task automatic test_gaps();
    int hs;
    do_load(3, 2, 1'b1, 'h10, 50, 1, 1'b0, hs);
    n_checks++;
    if (hs != 9) begin
      n_fail++;
      $display("FAIL gaps_handshakes: got %0d, required 9", hs);
    end
  endtask

  task automatic test_zero();
    int we0;
    int ack0;
    we0  = we_cnt;
    ack0 = ack_cnt;
    for (int c = 0; c < 2; c++) begin
      if (c == 0) start_job(0, 5, 1'b1, 0);
      else        start_job(4, 0, 1'b0, 0);
      @(posedge clk); #1;
      req = 1'b0;
      @(negedge clk);
      n_checks++;
      if (ack !== 1'b1 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL zero_ack: case %0d ack=%b busy=%b, required 1 1", c, ack, busy);
      end
      @(negedge clk);
      n_checks++;
      if (ack !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL zero_idle: case %0d ack=%b busy=%b, required 0 0", c, ack, busy);
      end
    end
    n_checks++;
    if (we_cnt != we0 || ack_cnt - ack0 != 2) begin
      n_fail++;
      $display("FAIL zero_counts: writes=%0d acks=%0d, required 0 2",
               we_cnt - we0, ack_cnt - ack0);
    end
  endtask

  task automatic test_req_busy();
    int hs;
    do_load(3, 2, 1'b1, 'h20, 0, 'h200, 1'b1, hs);
  endtask

  task automatic test_addr_wrap();
    int hs;
    do_load(1, 3, 1'b1, 'h7FE, 0, 'h300, 1'b0, hs);
  endtask

  task automatic test_reset_mid();
    int k;
    int cyc;
    int ack0;
    int hs;
    bit hit;
    k    = 0;
    cyc  = 0;
    ack0 = ack_cnt;
    push_exp(3, 2, 1'b1, 'h10, 1, 4);
    start_job(3, 2, 1'b1, 'h10);
    @(posedge clk); #1;
    req = 1'b0;
    while (k < 4 && cyc < 100) begin
      s_valid = 1'b1;
      s_data  = 16'(1 + k);
      @(negedge clk);
      hit = s_valid && s_ready;
      @(posedge clk); #1;
      if (hit) k++;
      cyc++;
    end
    s_valid = 1'b1;
    s_data  = 16'd5;
    xrst    = 1'b1;
    @(posedge clk); #1;
    xrst    = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (net_we !== 1'b0 || busy !== 1'b0 || ack !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_state: net_we=%b busy=%b ack=%b, required 0 0 0",
               net_we, busy, ack);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL reset_mid_writes: %0d pending, required 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    n_checks++;
    if (ack_cnt != ack0) begin
      n_fail++;
      $display("FAIL reset_mid_ack: got %0d acks, required 0", ack_cnt - ack0);
    end
    do_load(3, 2, 1'b1, 'h10, 0, 'h100, 1'b0, hs);
  endtask

  initial begin
    req        = 1'b0;
    net_offset = '0;
    total_out  = '0;
    total_in   = '0;
    bias_en    = 1'b0;
    s_valid    = 1'b0;
    s_data     = '0;
    test_reset();
    test_basic();
    test_core_wrap();
    test_gaps();
    test_zero();
    test_req_busy();
    test_addr_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
